solve_ctrl: RTL

- Parametrised successor of the top-level solve sequencer.
- Loads an initial cube state into the cube engine, then alternates network inference and move application until the cube engine reports solved or the step budget runs out.
- Records every applied move in a readable history buffer and reports a typed completion status.
- Sits between the host register interface, the cube engine and the network block.

---
 rtl/solve_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/solve_ctrl.sv
// Solve sequencer: store initial cube, then alternate network inference and move application.
// Optional SOLVE_TIMEOUT_EN adds a handshake watchdog that fails the solve after TIMEOUT_CYCLES.
module solve_ctrl #(
    parameter int STATE_W        = 120,
    parameter int MOVE_W         = 4,
    parameter int MAX_STEPS      = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = $clog2(MAX_STEPS + 1),
    localparam int AW            = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               abort,
    input  logic [STATE_W-1:0] init_state,
    output logic               cube_store,
    output logic               cube_load,
    output logic [MOVE_W-1:0]  cube_move,
    input  logic               cube_valid,
    input  logic               cube_solved,
    input  logic [STATE_W-1:0] cube_state,
    output logic               net_start,
    output logic [STATE_W-1:0] net_state,
    input  logic               net_valid,
    input  logic [MOVE_W-1:0]  net_move,
    input  logic [AW-1:0]      hist_rd_addr,
    output logic [MOVE_W-1:0]  hist_rd_data,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fail_code,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STORE   = 3'd1,
        S_NETWORK = 3'd2,
        S_APPLY   = 3'd3,
        S_FINISH  = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               cube_store_q, cube_store_d;
    logic               cube_load_q, cube_load_d;
    logic               net_start_q, net_start_d;
    logic [MOVE_W-1:0]  cube_move_q, cube_move_d;
    logic [STATE_W-1:0] net_state_q, net_state_d;
    logic [MOVE_W-1:0]  hist_rd_data_q, hist_rd_data_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [MOVE_W-1:0]  hist_q [MAX_STEPS];
    logic [MOVE_W-1:0]  hist_d [MAX_STEPS];
    logic [CNT_W-1:0]   step_inc;
    logic               in_wait;
    logic               timeout;

    // The cube engine captures init_state itself on the cube_store pulse.
    logic unused_init;
    assign unused_init = ^init_state;

    assign in_wait = (state_q == S_STORE) || (state_q == S_NETWORK) ||
                     (state_q == S_APPLY);
    assign step_inc = step_cnt_q + CNT_W'(1);

`ifdef SOLVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;

    assign timeout = in_wait && (wd_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if (state_d == state_q && in_wait) begin
            wd_d = wd_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cube_store_d = 1'b0;
        cube_load_d  = 1'b0;
        net_start_d  = 1'b0;
        cube_move_d  = cube_move_q;
        net_state_d  = net_state_q;
        step_cnt_d   = step_cnt_q;
        fail_code_d  = fail_code_q;
        hist_d       = hist_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FINISH, S_FAIL: begin
                    if (run) begin
                        state_d      = S_STORE;
                        cube_store_d = 1'b1;
                        step_cnt_d   = '0;
                        fail_code_d  = 2'd0;
                    end
                end
                S_STORE: begin
                    if (cube_valid) begin
                        net_state_d = cube_state;
                        if (cube_solved) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d     = S_NETWORK;
                            net_start_d = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d     = S_FAIL;
                        fail_code_d = 2'd2;
                    end
                end
                S_NETWORK: begin
                    if (net_valid) begin
                        cube_move_d = net_move;
                        for (int i = 0; i < MAX_STEPS; i++) begin
                            if (step_cnt_q == CNT_W'(i)) begin
                                hist_d[i] = net_move;
                            end
                        end
                        state_d     = S_APPLY;
                        cube_load_d = 1'b1;
                    end else if (timeout) begin
                        state_d     = S_FAIL;
                        fail_code_d = 2'd2;
                    end
                end
                S_APPLY: begin
                    if (cube_valid) begin
                        step_cnt_d  = step_inc;
                        net_state_d = cube_state;
                        // Solved on the final budgeted move still counts as a finish.
                        if (cube_solved) begin
                            state_d = S_FINISH;
                        end else if (step_inc == CNT_W'(MAX_STEPS)) begin
                            state_d     = S_FAIL;
                            fail_code_d = 2'd1;
                        end else begin
                            state_d     = S_NETWORK;
                            net_start_d = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d     = S_FAIL;
                        fail_code_d = 2'd2;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        hist_rd_data_d = '0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            if (hist_rd_addr == AW'(i)) begin
                hist_rd_data_d = hist_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cube_store_q   <= 1'b0;
            cube_load_q    <= 1'b0;
            net_start_q    <= 1'b0;
            cube_move_q    <= '0;
            net_state_q    <= '0;
            hist_rd_data_q <= '0;
            step_cnt_q     <= '0;
            fail_code_q    <= 2'd0;
            for (int i = 0; i < MAX_STEPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cube_store_q   <= cube_store_d;
            cube_load_q    <= cube_load_d;
            net_start_q    <= net_start_d;
            cube_move_q    <= cube_move_d;
            net_state_q    <= net_state_d;
            hist_rd_data_q <= hist_rd_data_d;
            step_cnt_q     <= step_cnt_d;
            fail_code_q    <= fail_code_d;
            for (int i = 0; i < MAX_STEPS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign cube_store   = cube_store_q;
    assign cube_load    = cube_load_q;
    assign net_start    = net_start_q;
    assign cube_move    = cube_move_q;
    assign net_state    = net_state_q;
    assign hist_rd_data = hist_rd_data_q;
    assign step_cnt     = step_cnt_q;
    assign fail_code    = fail_code_q;
    assign busy         = in_wait;
    assign done         = (state_q == S_FINISH);
    assign state_out    = state_q;

endmodule
